regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the default widths, the requester-index constants used to index
// grant/ready vectors, and the encoding of the last-grant register.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREGS_DEF  = 16;

    // Requester indices into the 2-bit valid/grant vectors.
    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LD  = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   valid[1:0]  - request vector, indexed by REQ_ALU / REQ_LD
//   grant[1:0]  - combinational one-hot grant, never set without valid
// On a tie the requester that did not win most recently is granted. The
// last-grant register only moves on a transfer; it resets to the load
// requester so the ALU requester wins the first tie.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    grant_e lastGrant;

    always_comb begin
        grant = '0;
        unique case (valid)
            2'b01:   grant[REQ_ALU] = 1'b1;
            2'b10:   grant[REQ_LD]  = 1'b1;
            2'b11: begin
                if (lastGrant == GRANT_LD) grant[REQ_ALU] = 1'b1;
                else                       grant[REQ_LD]  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastGrant <= GRANT_LD;
        end else if (|grant) begin
            lastGrant <= grant[REQ_LD] ? GRANT_LD : GRANT_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Merges the ALU and load writeback streams onto the single register-file
// write port with one cycle of latency.
// Ports:
//   clk, reset               - clock, asynchronous active-low reset
//   req0_* (ALU), req1_* (load) - valid/ready handshake with addr and data
//   regWrite, wrAddr, wrData - registered register-file write port
//   busy_mask                - per-register write-in-flight flags
//   drop_count               - saturating count of discarded writes
// Writes to register 0 or to an address beyond NREGS are accepted so the
// requester never stalls on them, but they are counted and dropped.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              regWrite,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic [NREGS-1:0]  busy_mask,
    output logic [7:0]        drop_count
);

    logic [1:0]        reqValid;
    logic [1:0]        grant;
    logic              xfer;
    logic              addrOk;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;
    logic [NREGS-1:0]  busySet;
    logic [NREGS-1:0]  busyClr;

    // Masking with reset keeps both readies low while reset is held.
    assign reqValid = {req1_valid, req0_valid} & {2{reset}};

    rr_arb2 uArb (
        .clk   (clk),
        .reset (reset),
        .valid (reqValid),
        .grant (grant)
    );

    assign req0_ready = grant[REQ_ALU];
    assign req1_ready = grant[REQ_LD];
    assign xfer       = |grant;
    assign selAddr    = grant[REQ_LD] ? req1_addr : req0_addr;
    assign selData    = grant[REQ_LD] ? req1_data : req0_data;
    assign addrOk     = (selAddr != '0) && (32'(selAddr) < NREGS);

    always_comb begin
        busySet = '0;
        busyClr = '0;
        for (int k = 0; k < NREGS; k++) begin
            busySet[k] = xfer && addrOk && (selAddr == ADDR_W'(k));
            busyClr[k] = regWrite && (wrAddr == ADDR_W'(k));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWrite   <= 1'b0;
            wrAddr     <= '0;
            wrData     <= '0;
            busy_mask  <= '0;
            drop_count <= '0;
        end else begin
            regWrite <= xfer && addrOk;
            // Write port holds the last real write; discards do not disturb it.
            if (xfer && addrOk) begin
                wrAddr <= selAddr;
                wrData <= selData;
            end
            // Set wins over clear so a back-to-back rewrite stays busy.
            busy_mask <= (busy_mask & ~busyClr) | busySet;
            if (xfer && !addrOk && drop_count != DROP_MAX) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule
